// File: rtl/pcie_tlp_pkg.sv
// TLP encodings, header field positions and decoder FSM states shared by the
// receive-side request decoder.
package pcie_tlp_pkg;

    localparam logic [1:0] FmtRd3 = 2'b00;
    localparam logic [1:0] FmtRd4 = 2'b01;
    localparam logic [1:0] FmtWr3 = 2'b10;
    localparam logic [1:0] FmtWr4 = 2'b11;

    localparam logic [4:0] TypeMem = 5'b00000;

    // DW0 field LSBs
    localparam int unsigned Dw0FmtLsb  = 29;
    localparam int unsigned Dw0TypeLsb = 24;
    localparam int unsigned Dw0TcLsb   = 20;
    localparam int unsigned Dw0AttrLsb = 12;
    localparam int unsigned Dw0LenLsb  = 0;

    // DW1 field LSBs
    localparam int unsigned Dw1ReqIdLsb   = 16;
    localparam int unsigned Dw1TagLsb     = 8;
    localparam int unsigned Dw1LastBeLsb  = 4;
    localparam int unsigned Dw1FirstBeLsb = 0;

    typedef enum logic [2:0] {
        StHdr,
        StAdr3,
        StAdr4,
        StDat4,
        StRdHold,
        StDrop
    } rx_state_e;

    function automatic logic fmt_is_4dw(input logic [1:0] fmt);
        return (fmt == FmtRd4) || (fmt == FmtWr4);
    endfunction

    function automatic logic fmt_is_write(input logic [1:0] fmt);
        return (fmt == FmtWr3) || (fmt == FmtWr4);
    endfunction

endpackage

// File: rtl/pcie_rx_req_decoder_if.sv
// Receive stream plus register-write and read-request channels of the decoder.
interface pcie_rx_req_decoder_if #(
    parameter int unsigned ADDR_W = 10
);

    logic [63:0]       m_axis_rx_tdata;
    logic [7:0]        m_axis_rx_tkeep;
    logic              m_axis_rx_tlast;
    logic              m_axis_rx_tvalid;
    logic              m_axis_rx_tready;
    logic [21:0]       m_axis_rx_tuser;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_req_id;
    logic [7:0]        rd_tag;
    logic [2:0]        rd_tc;
    logic [1:0]        rd_attr;
    logic [3:0]        rd_be;

    modport slave (
        input  m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
        input  m_axis_rx_tuser, rd_ready,
        output m_axis_rx_tready,
        output wr_en, wr_addr, wr_data, wr_be,
        output rd_valid, rd_addr, rd_req_id, rd_tag, rd_tc, rd_attr, rd_be
    );

    modport master (
        output m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
        output m_axis_rx_tuser, rd_ready,
        input  m_axis_rx_tready,
        input  wr_en, wr_addr, wr_data, wr_be,
        input  rd_valid, rd_addr, rd_req_id, rd_tag, rd_tc, rd_attr, rd_be
    );

endinterface

// File: rtl/pcie_rx_req_decoder.sv
// Parses inbound TLPs: single-DW MWr becomes a register write strobe, single-DW MRd a held
// read request for the completion generator; everything else is consumed and dropped.
module pcie_rx_req_decoder
    import pcie_tlp_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [6:0]  BAR_MASK = 7'b0000001
) (
    input logic                  user_clk,
    input logic                  user_reset,
    pcie_rx_req_decoder_if.slave rx
);

    rx_state_e state_q, state_d;

    logic              tready_q;
    logic              xfer;
    logic              tlast;
    logic [31:0]       dw_lo, dw_hi;
    logic [1:0]        fmt;
    logic              hdr_ok;
    logic [ADDR_W-1:0] adr_lo, adr_hi;

    // Header fields held from the header beat until the request executes
    logic              is_wr_q;
    logic [3:0]        fbe_q;
    logic [15:0]       req_id_q;
    logic [7:0]        tag_q;
    logic [2:0]        tc_q;
    logic [1:0]        attr_q;
    logic [ADDR_W-1:0] addr4_q;
    logic              tail_q, tail_d;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic [3:0]        wr_be_q;
    logic              rd_valid_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [15:0]       rd_req_id_q;
    logic [7:0]        rd_tag_q;
    logic [2:0]        rd_tc_q;
    logic [1:0]        rd_attr_q;
    logic [3:0]        rd_be_q;

    logic              wr_fire, rd_load, rd_done;
    logic [ADDR_W-1:0] wr_addr_n, rd_addr_n;
    logic [31:0]       wr_data_n;
    logic              unused_bits;

    assign xfer    = rx.m_axis_rx_tvalid & tready_q;
    assign tlast   = rx.m_axis_rx_tlast;
    assign dw_lo   = rx.m_axis_rx_tdata[31:0];
    assign dw_hi   = rx.m_axis_rx_tdata[63:32];
    assign fmt     = dw_lo[Dw0FmtLsb +: 2];
    assign adr_lo  = dw_lo[ADDR_W+1:2];
    assign adr_hi  = dw_hi[ADDR_W+1:2];
    assign rd_done = rd_valid_q & rx.rd_ready;

    assign hdr_ok = (dw_lo[Dw0TypeLsb +: 5] == TypeMem) &&
                    (dw_lo[Dw0LenLsb +: 10] == 10'd1) &&
                    (dw_hi[Dw1LastBeLsb +: 4] == 4'h0) &&
                    ((rx.m_axis_rx_tuser[8:2] & BAR_MASK) != 7'd0);

    assign unused_bits = ^{rx.m_axis_rx_tkeep, rx.m_axis_rx_tuser, rx.m_axis_rx_tdata};

    always_comb begin
        state_d   = state_q;
        tail_d    = tail_q;
        wr_fire   = 1'b0;
        rd_load   = 1'b0;
        wr_addr_n = adr_lo;
        wr_data_n = dw_hi;
        rd_addr_n = adr_lo;
        unique case (state_q)
            StHdr: begin
                // An accepted header that already carries tlast is truncated: stay put
                if (xfer && !tlast) begin
                    if (hdr_ok) state_d = fmt_is_4dw(fmt) ? StAdr4 : StAdr3;
                    else        state_d = StDrop;
                end
            end
            StAdr3: begin
                if (xfer) begin
                    if (is_wr_q) begin
                        wr_fire = 1'b1;
                        state_d = tlast ? StHdr : StDrop;
                    end else begin
                        rd_load = 1'b1;
                        tail_d  = !tlast;
                        state_d = StRdHold;
                    end
                end
            end
            StAdr4: begin
                if (xfer) begin
                    if (is_wr_q) begin
                        state_d = tlast ? StHdr : StDat4;
                    end else begin
                        rd_load   = 1'b1;
                        rd_addr_n = adr_hi;
                        tail_d    = !tlast;
                        state_d   = StRdHold;
                    end
                end
            end
            StDat4: begin
                if (xfer) begin
                    wr_fire   = 1'b1;
                    wr_addr_n = addr4_q;
                    wr_data_n = dw_lo;
                    state_d   = tlast ? StHdr : StDrop;
                end
            end
            StRdHold: begin
                // A read that lacked tlast still has beats to swallow afterwards
                if (rd_done) state_d = tail_q ? StDrop : StHdr;
            end
            StDrop: begin
                if (xfer && tlast) state_d = StHdr;
            end
            default: state_d = StHdr;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_q     <= StHdr;
            tready_q    <= 1'b0;
            tail_q      <= 1'b0;
            is_wr_q     <= 1'b0;
            fbe_q       <= '0;
            req_id_q    <= '0;
            tag_q       <= '0;
            tc_q        <= '0;
            attr_q      <= '0;
            addr4_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_be_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_req_id_q <= '0;
            rd_tag_q    <= '0;
            rd_tc_q     <= '0;
            rd_attr_q   <= '0;
            rd_be_q     <= '0;
        end else begin
            state_q  <= state_d;
            tready_q <= (state_d != StRdHold);
            tail_q   <= tail_d;
            wr_en_q  <= wr_fire;
            if (state_q == StHdr && xfer) begin
                is_wr_q  <= fmt_is_write(fmt);
                fbe_q    <= dw_hi[Dw1FirstBeLsb +: 4];
                req_id_q <= dw_hi[Dw1ReqIdLsb +: 16];
                tag_q    <= dw_hi[Dw1TagLsb +: 8];
                tc_q     <= dw_lo[Dw0TcLsb +: 3];
                attr_q   <= dw_lo[Dw0AttrLsb +: 2];
            end
            if (state_q == StAdr4 && xfer) addr4_q <= adr_hi;
            if (wr_fire) begin
                wr_addr_q <= wr_addr_n;
                wr_data_q <= wr_data_n;
                wr_be_q   <= fbe_q;
            end
            if (rd_load) begin
                rd_valid_q  <= 1'b1;
                rd_addr_q   <= rd_addr_n;
                rd_req_id_q <= req_id_q;
                rd_tag_q    <= tag_q;
                rd_tc_q     <= tc_q;
                rd_attr_q   <= attr_q;
                rd_be_q     <= fbe_q;
            end else if (rd_done) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign rx.m_axis_rx_tready = tready_q;
    assign rx.wr_en            = wr_en_q;
    assign rx.wr_addr          = wr_addr_q;
    assign rx.wr_data          = wr_data_q;
    assign rx.wr_be            = wr_be_q;
    assign rx.rd_valid         = rd_valid_q;
    assign rx.rd_addr          = rd_addr_q;
    assign rx.rd_req_id        = rd_req_id_q;
    assign rx.rd_tag           = rd_tag_q;
    assign rx.rd_tc            = rd_tc_q;
    assign rx.rd_attr          = rd_attr_q;
    assign rx.rd_be            = rd_be_q;

endmodule
